// File: rtl/loader_pkg.sv
// Shared constants for the byte-stream program loader.
//   - Header command codes recognised in IDLE.
//   - FSM state encoding.
package loader_pkg;

    localparam logic [7:0] CMD_LOAD_INS = 8'h01;
    localparam logic [7:0] CMD_LOAD_DAT = 8'h02;
    localparam logic [7:0] CMD_RUN      = 8'hA5;
    localparam logic [7:0] CMD_CLR_ERR  = 8'h5A;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAddr  = 3'd1;
    localparam logic [2:0] StCount = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StWrite = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

endpackage

// File: rtl/program_loader.sv
// program_loader: parses framed load/run commands from an 8-bit valid/ready byte
// stream and loads the core's instruction/data memories word by word.
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   in_data/in_valid/in_ready    byte stream (transfer when valid & ready)
//   write_ins/addr_ins/dati_ins  instruction-memory write port
//   write_data/addr_data/dati_data data-memory write port
//   core_reset_n                 holds the core in reset while low
//   busy, load_done, frame_err   frame status
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              write_ins,
    output logic [ADDR_W-1:0] addr_ins,
    output logic [DATA_W-1:0] dati_ins,
    output logic              write_data,
    output logic [ADDR_W-1:0] addr_data,
    output logic [DATA_W-1:0] dati_data,
    output logic              core_reset_n,
    output logic              busy,
    output logic              load_done,
    output logic              frame_err
);

    logic [2:0]        state_q, state_d;
    logic              tgt_dat_q, tgt_dat_d;     // 1: data memory, 0: instruction memory
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        count_q, count_d;         // 9 bits so a count byte of 0 can mean 256
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_ins_q, wr_ins_d;
    logic              wr_dat_q, wr_dat_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [DATA_W-1:0] asm_next;

    assign accept   = in_valid & in_ready_q;
    // LSB first: each new byte enters at the top and earlier bytes shift down.
    assign asm_next = {in_data, asm_q[DATA_W-1:8]};

    always_comb begin
        state_d      = state_q;
        tgt_dat_d    = tgt_dat_q;
        addr_d       = addr_q;
        count_d      = count_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        core_rst_n_d = core_rst_n_q;
        err_d        = err_q;
        wr_ins_d     = 1'b0;
        wr_dat_d     = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (in_data)
                        CMD_LOAD_INS, CMD_LOAD_DAT: begin
                            state_d      = StAddr;
                            tgt_dat_d    = (in_data == CMD_LOAD_DAT);
                            core_rst_n_d = 1'b0;
                        end
                        CMD_RUN:     core_rst_n_d = 1'b1;
                        CMD_CLR_ERR: err_d = 1'b0;
                        default:     err_d = 1'b1;
                    endcase
                end
            end
            StAddr: begin
                if (accept) begin
                    addr_d  = ADDR_W'(in_data);
                    state_d = StCount;
                end
            end
            StCount: begin
                if (accept) begin
                    count_d    = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    byte_idx_d = 2'd0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (accept) begin
                    asm_d      = asm_next;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Launch the strobe now so it is high in the WRITE cycle.
                        wr_ins_d   = ~tgt_dat_q;
                        wr_dat_d   = tgt_dat_q;
                        bus_addr_d = addr_q;
                        bus_data_d = asm_next;
                        state_d    = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 9'd1;
                if (count_q == 9'd1) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StData;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d != StWrite) && (state_d != StDone);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            tgt_dat_q    <= 1'b0;
            addr_q       <= '0;
            count_q      <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            in_ready_q   <= 1'b0;
            wr_ins_q     <= 1'b0;
            wr_dat_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_dat_q    <= tgt_dat_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            in_ready_q   <= in_ready_d;
            wr_ins_q     <= wr_ins_d;
            wr_dat_q     <= wr_dat_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign write_ins    = wr_ins_q;
    assign write_data   = wr_dat_q;
    assign addr_ins     = bus_addr_q;
    assign addr_data    = bus_addr_q;
    assign dati_ins     = bus_data_q;
    assign dati_data    = bus_data_q;
    assign core_reset_n = core_rst_n_q;
    assign busy         = busy_q;
    assign load_done    = done_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: streams hand-built frames and checks the
// memory write strobes, status outputs and core reset control.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        write_ins, write_data;
    logic [7:0]  addr_ins, addr_data;
    logic [31:0] dati_ins, dati_data;
    logic        core_reset_n, busy, load_done, frame_err;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0]  ins_a[$];
    logic [31:0] ins_d[$];
    logic [7:0]  dat_a[$];
    logic [31:0] dat_d[$];
    int          done_cnt = 0;
    int          rdy_viol = 0;
    int          both_viol = 0;

    program_loader #(.ADDR_W(8), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .write_ins    (write_ins),
        .addr_ins     (addr_ins),
        .dati_ins     (dati_ins),
        .write_data   (write_data),
        .addr_data    (addr_data),
        .dati_data    (dati_data),
        .core_reset_n (core_reset_n),
        .busy         (busy),
        .load_done    (load_done),
        .frame_err    (frame_err)
    );

    always #5 clock = ~clock;

    // Record every strobe mid-cycle.
    always @(negedge clock) begin
        if (write_ins) begin
            ins_a.push_back(addr_ins);
            ins_d.push_back(dati_ins);
            if (in_ready) rdy_viol++;
        end
        if (write_data) begin
            dat_a.push_back(addr_data);
            dat_d.push_back(dati_data);
            if (in_ready) rdy_viol++;
        end
        if (write_ins && write_data) both_viol++;
        if (load_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_log();
        ins_a.delete(); ins_d.delete(); dat_a.delete(); dat_d.delete();
        done_cnt = 0;
        rdy_viol = 0;
        both_viol = 0;
    endtask

    // Present one byte at a negedge once in_ready is seen, with optional idle gap.
    task automatic send(input logic [7:0] b, input int gap = 0);
        int n = 0;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'd1, 32'd0);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clock);
        while ((busy || !in_ready) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk({tag, "_idle_timeout"}, 32'd1, 32'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        int          bad;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_write_ins", {31'd0, write_ins}, 32'd0);
        chk("rst_write_data", {31'd0, write_data}, 32'd0);
        chk("rst_addr_ins", {24'd0, addr_ins}, 32'd0);
        chk("rst_dati_data", dati_data, 32'd0);
        chk("rst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Two-word instruction load at 0x10
        clear_log();
        send(8'h01);
        chk("busy_after_hdr", {31'd0, busy}, 32'd1);
        send(8'h10); send(8'h02);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        wait_idle("f1");
        chk("f1_ins_count", ins_a.size(), 32'd2);
        if (ins_a.size() == 2) begin
            chk("f1_addr0", {24'd0, ins_a[0]}, 32'h10);
            chk("f1_data0", ins_d[0], 32'h0000_0013);
            chk("f1_addr1", {24'd0, ins_a[1]}, 32'h11);
            chk("f1_data1", ins_d[1], 32'h0010_0093);
        end
        chk("f1_dat_count", dat_a.size(), 32'd0);
        chk("f1_done_count", done_cnt, 32'd1);
        chk("f1_ready_on_strobe", rdy_viol, 32'd0);
        chk("f1_core_reset_n", {31'd0, core_reset_n}, 32'd0);

        // Data load wrapping 0xFF -> 0x00
        clear_log();
        send(8'h02); send(8'hFF); send(8'h02);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        wait_idle("f2");
        chk("f2_dat_count", dat_a.size(), 32'd2);
        if (dat_a.size() == 2) begin
            chk("f2_addr0", {24'd0, dat_a[0]}, 32'hFF);
            chk("f2_data0", dat_d[0], 32'h4433_2211);
            chk("f2_addr1_wrap", {24'd0, dat_a[1]}, 32'h00);
            chk("f2_data1", dat_d[1], 32'h8877_6655);
        end
        chk("f2_ins_count", ins_a.size(), 32'd0);
        chk("f2_done_count", done_cnt, 32'd1);

        // 256-word load (count byte 0) with random valid gaps
        clear_log();
        send(8'h01); send(8'h00); send(8'h00);
        for (int i = 0; i < 1024; i++) begin
            b = 8'((i * 7 + 3) & 32'hFF);
            send(b, int'($urandom_range(0, 2)));
        end
        wait_idle("f3");
        chk("f3_ins_count", ins_a.size(), 32'd256);
        bad = 0;
        for (int k = 0; k < ins_a.size() && k < 256; k++) begin
            for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(((4 * k + j) * 7 + 3) & 32'hFF);
            if (ins_a[k] !== 8'(k) || ins_d[k] !== w) bad++;
        end
        chk("f3_bad_words", bad, 32'd0);
        chk("f3_ready_on_strobe", rdy_viol, 32'd0);
        chk("f3_done_count", done_cnt, 32'd1);
        chk("f3_both_strobes", both_viol, 32'd0);

        // Error / clear / run commands
        clear_log();
        send(8'h7E);
        @(negedge clock);
        chk("err_set", {31'd0, frame_err}, 32'd1);
        chk("err_busy", {31'd0, busy}, 32'd0);
        send(8'h5A);
        chk("err_clear", {31'd0, frame_err}, 32'd0);
        chk("pre_run_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        send(8'hA5);
        chk("run_core_reset_n", {31'd0, core_reset_n}, 32'd1);
        repeat (3) @(negedge clock);
        chk("err_no_strobe", ins_a.size() + dat_a.size(), 32'd0);

        // Reset in the middle of a frame
        clear_log();
        send(8'h01);
        chk("hdr_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        send(8'h20); send(8'h01); send(8'hAA); send(8'hBB);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("midrst_no_strobe", ins_a.size() + dat_a.size(), 32'd0);
        chk("midrst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        send(8'h01); send(8'h30); send(8'h01);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        wait_idle("f5");
        chk("f5_ins_count", ins_a.size(), 32'd1);
        if (ins_a.size() == 1) begin
            chk("f5_addr", {24'd0, ins_a[0]}, 32'h30);
            chk("f5_data", ins_d[0], 32'h0403_0201);
        end

        // 0xA5 as payload is data, not a run command
        clear_log();
        send(8'h02); send(8'h40); send(8'h01);
        send(8'hA5); send(8'hA5); send(8'hA5); send(8'hA5);
        wait_idle("f6");
        chk("f6_dat_count", dat_a.size(), 32'd1);
        if (dat_a.size() == 1) begin
            chk("f6_addr", {24'd0, dat_a[0]}, 32'h40);
            chk("f6_data", dat_d[0], 32'hA5A5_A5A5);
        end
        chk("f6_core_reset_n_held", {31'd0, core_reset_n}, 32'd0);
        send(8'hA5);
        chk("f6_run", {31'd0, core_reset_n}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
